// File: rtl/fp_add_normalizer.sv
// fp_add_normalizer: post-adder stage of the add datapath.
// Converts the fraction ALU's two's-complement sum/carry into sign-magnitude,
// then renormalises one step per cycle so the hidden bit lands in FracOut[N-1],
// adjusting the exponent alongside.
//
// Optional feature macro: ROUND_NEAREST_EN
//   defined   -> right shifts round half-to-even on the dropped bit
//   undefined -> right shifts truncate
//
// Ports:
//   Clock, Reset         rising-edge clock, synchronous active-high reset
//   InValid / InReady    upstream handshake (ready only in IDLE)
//   Result, ccc          two's-complement sum and carry-out from the ALU
//   SignA, SignB         operand signs fed to the ALU
//   ExpIn                common aligned exponent
//   OutValid / OutReady  downstream handshake (valid only in DONE)
//   SignOut, FracOut, ExpOut  normalised result
//   Zero, Overflow, Underflow mutually exclusive status flags
module fp_add_normalizer #(
  parameter int N = 24,
  parameter int E = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         InValid,
  output logic         InReady,
  input  logic [N-1:0] Result,
  input  logic         ccc,
  input  logic         SignA,
  input  logic         SignB,
  input  logic [E-1:0] ExpIn,
  output logic         OutValid,
  input  logic         OutReady,
  output logic         SignOut,
  output logic [N-1:0] FracOut,
  output logic [E-1:0] ExpOut,
  output logic         Zero,
  output logic         Overflow,
  output logic         Underflow
);

  localparam logic [E-1:0] EXP_MAX    = '1;
  localparam logic [E-1:0] EXP_MAX_M1 = {{(E-1){1'b1}}, 1'b0};
  localparam logic [E-1:0] EXP_ONE    = {{(E-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t       state, state_nxt;
  logic [N:0]   mag, mag_in, mag_rsh, sum_ext;
  logic [N-1:0] neg_res;
  logic         sign, sign_in;
  logic [E-1:0] exp_q;
  logic         zero_q, ovf_q, unf_q;
  logic         exp_near_max;

  // Sign/magnitude recovery from the raw ALU sum.
  // With differing signs a carry-out means the positive operand dominated,
  // so the result sign is 0; no carry means the negative one dominated.
  always_comb begin
    sum_ext = {ccc, Result};
    neg_res = '0 - Result;
    mag_in  = sum_ext;
    sign_in = 1'b0;
    if (SignA == SignB) begin
      if (SignA) begin
        mag_in  = '0 - sum_ext;
        sign_in = 1'b1;
      end
    end else if (ccc) begin
      mag_in  = {1'b0, Result};
      sign_in = 1'b0;
    end else begin
      mag_in  = {1'b0, neg_res};
      sign_in = 1'b1;
    end
  end

  // Right-shift step. A rounding carry may set mag[N] again; the FSM simply
  // sees that on the next NORM cycle and shifts once more.
  always_comb begin
`ifdef ROUND_NEAREST_EN
    mag_rsh = (mag >> 1) + {{N{1'b0}}, (mag[0] & mag[1])};
`else
    mag_rsh = mag >> 1;
`endif
  end

  assign exp_near_max = (exp_q >= EXP_MAX_M1);

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; NORM exits on any terminal action of the priority list
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (InValid) state_nxt = NORM;
      NORM: begin
        if (mag == '0)                 state_nxt = DONE;
        else if (mag[N] && exp_near_max) state_nxt = DONE;
        else if (mag[N])               state_nxt = NORM;
        else if (mag[N-1])             state_nxt = DONE;
        else if (exp_q == '0)          state_nxt = DONE;
        else                           state_nxt = NORM;
      end
      DONE: if (OutReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    InReady  = (state == IDLE);
    OutValid = (state == DONE);
  end

  // Datapath: capture in IDLE, one normalisation action per NORM cycle
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mag    <= '0;
      sign   <= 1'b0;
      exp_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (InValid) begin
          mag    <= mag_in;
          sign   <= sign_in;
          exp_q  <= ExpIn;
          zero_q <= 1'b0;
          ovf_q  <= 1'b0;
          unf_q  <= 1'b0;
        end
        NORM: begin
          if (mag == '0) begin
            zero_q <= 1'b1;
            sign   <= 1'b0;
            exp_q  <= '0;
          end else if (mag[N] && exp_near_max) begin
            ovf_q <= 1'b1;
            exp_q <= EXP_MAX;
            mag   <= '0;
          end else if (mag[N]) begin
            mag   <= mag_rsh;
            exp_q <= exp_q + EXP_ONE;
          end else if (mag[N-1]) begin
            // already normalised: hold
          end else if (exp_q == '0) begin
            unf_q <= 1'b1;
          end else begin
            mag   <= mag << 1;
            exp_q <= exp_q - EXP_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign SignOut   = sign;
  assign FracOut   = mag[N-1:0];
  assign ExpOut    = exp_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: doc/fp_add_normalizer.md
Name: fp_add_normalizer

Overview:
- Post-adder stage of the fixed/floating-point add datapath; consumes the two's-complement sum and carry produced by the fraction ALU.
- Recovers sign-magnitude, then renormalises so the hidden bit lands in FracOut[N-1], adjusting the exponent one step per cycle.
- Sits between the fraction ALU and result packing; valid/ready on both sides.

Parameters:
- N, 24, fraction width (hidden bit included); must match the fraction ALU width.
- E, 8, exponent width; ExpMax = 2^E-1.

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- InValid  input  1  upstream holds sum/operand fields valid
- InReady  output  1  block can accept a sum (IDLE only)
- Result  input  N  two's-complement sum from the fraction ALU
- ccc  input  1  adder carry-out
- SignA, SignB  input  1 each  operand signs fed to the fraction ALU
- ExpIn  input  E  common aligned exponent
- OutValid  output  1  normalised result valid
- OutReady  input  1  downstream accepts result
- SignOut  output  1  result sign
- FracOut  output  N  normalised magnitude
- ExpOut  output  E  adjusted exponent
- Zero, Overflow, Underflow  output  1 each  result status

Behaviour:
- Clock and reset: one clock (Clock); Reset is synchronous and active-high. Reset returns the FSM to IDLE from any state, including mid-shift, and discards the captured operation.
- Reset values: InReady=1 after the reset cycle; OutValid=0; SignOut, FracOut, ExpOut, Zero, Overflow and Underflow all 0.
- States: IDLE, NORM, DONE.
- IDLE: InReady=1. On InValid&&InReady, capture, build magnitude Mag (N+1 bits) and Sign, then go to NORM.
- Sign and magnitude recovery:
  - SignA==SignB==0: Mag={ccc,Result}, Sign=0.
  - SignA==SignB==1: Mag=(2^(N+1)-{ccc,Result}) mod 2^(N+1), Sign=1.
  - Signs differ, ccc=1: Mag={1'b0,Result}, Sign=sign of the positive operand.
  - Signs differ, ccc=0: Mag={1'b0,(2^N-Result) mod 2^N}, Sign=sign of the negative operand.
  - Interface contract: when signs differ, the negated fraction is nonzero. Upstream special-cases zero operands; the bench does not drive this case.
- NORM, one action per cycle, priority order:
  1. Mag==0: Zero=1; Sign, Frac and Exp forced to 0; go to DONE.
  2. Mag[N]=1 and Exp>=ExpMax-1: Overflow=1, Exp=ExpMax, Frac=0; go to DONE.
  3. Mag[N]=1: Mag>>=1 (LSB truncated), Exp+=1.
  4. Mag[N-1]=1: go to DONE.
  5. Exp==0: Underflow=1; Frac=Mag[N-1:0] unnormalised; go to DONE.
  6. Otherwise: Mag<<=1, Exp-=1.
- Latency: OutValid rises 1+S cycles after the accept edge, where S is the number of shift steps. S=0 when the sum is already normalised or zero; S=1 for a carry; S is at most N-1 for left shifts.
- DONE:
  - OutValid=1; outputs stay stable until OutReady.
  - On OutValid&&OutReady, go to IDLE; OutValid drops the next cycle.
  - InReady=0 in NORM and DONE, so there is no same-cycle back-to-back accept.
  - Flags are mutually exclusive and cleared on each new accept.
- Arithmetic: the exponent never wraps. Decrements stop at 0; increments saturate to ExpMax with Overflow set.

Optional Feature:
- Macro: ROUND_NEAREST_EN.
- Defined: a right shift rounds half-to-even on the dropped bit. If the dropped bit is 1 and the kept LSB is 1, add 1.
  - A rounding carry that sets Mag[N] again takes one more right-shift step (S+1).
- Undefined: pure truncation on right shifts.

Test Plan:
1. Positive carry: SignA=SignB=0, Result=0x000000, ccc=1, ExpIn=0x80 -> FracOut=0x800000, ExpOut=0x81, SignOut=0, all flags 0, OutValid 2 cycles after accept.
2. Deep cancellation: SignA=0, SignB=1, Result=0x000001, ccc=1, ExpIn=0x80 -> 23 left shifts, FracOut=0x800000, ExpOut=0x69, OutValid 24 cycles after accept.
3. Exact cancel: signs differ, Result=0x000000, ccc=1 -> Zero=1, SignOut=0, FracOut=0, ExpOut=0, 1-cycle latency.
4. Both negative: SignA=SignB=1, Result=0x800000, ccc=1, ExpIn=0x40 -> SignOut=1, FracOut=0x800000, ExpOut=0x40; then hold OutReady=0 for 5 cycles -> outputs stable, InReady=0.
5. Overflow/underflow:
   - ccc=1, same positive signs, ExpIn=0xFE -> Overflow=1, ExpOut=0xFF, FracOut=0.
   - Result=0x000001, signs differ, ccc=1, ExpIn=0x03 -> Underflow=1, ExpOut=0, FracOut=0x000008.
6. Reset mid-NORM during test 2 at shift 10 -> next cycle IDLE, InReady=1, OutValid=0, all outputs 0; a fresh test-1 op completes correctly.
